// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the instruction memory (slave).
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches from instruction memory, buffers one
// instruction while decode stalls and applies decode redirects after the delay slot.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wpcir,
    input  logic        cu_branch,
    input  logic [31:0] cu_bpc,
    if_stage_if.master  imem,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc4,
    output logic [3:0]  IF_ins_type,
    output logic [3:0]  IF_ins_number
);

    typedef enum logic {FETCH, HOLD} state_t;

    state_t      state, state_next;
    logic [31:0] pc, ibuf, redir_pc, next_pc, cur_inst;
    logic        redir_pend, valid, consume, capture;
    logic [3:0]  seq, cur_type;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= FETCH;
        else
            state <= state_next;
    end

    // Everything is gated by rst so the outputs read as a bubble for the whole reset pulse.
    always_comb begin
        state_next = state;
        valid      = !rst && ((state == FETCH && imem.imem_ready) || state == HOLD);
        consume    = valid && wpcir;
        capture    = valid && !wpcir && state == FETCH;
        cur_inst   = (state == HOLD) ? ibuf : imem.imem_rdata;
        cur_type   = 4'd0;

        if (consume)
            state_next = FETCH;
        else if (capture)
            state_next = HOLD;

        if (cu_branch)
            next_pc = cu_bpc;
        else if (redir_pend)
            next_pc = redir_pc;
        else
            next_pc = pc + 32'd4;

        case (cur_inst[31:26])
            6'h00:         cur_type = (cur_inst[5:0] == 6'h08) ? 4'd7 : 4'd1;
            6'h23:         cur_type = 4'd3;
            6'h2B:         cur_type = 4'd4;
            6'h04, 6'h05:  cur_type = 4'd5;
            6'h02, 6'h03:  cur_type = 4'd6;
            default:       cur_type = 4'd2;
        endcase

        imem.imem_req  = !rst && state == FETCH;
        imem.imem_addr = rst ? 32'd0 : pc;
        if_inst        = valid ? cur_inst : 32'd0;
        if_pc4         = valid ? pc + 32'd4 : 32'd0;
        IF_ins_type    = valid ? cur_type : 4'd0;
        IF_ins_number  = valid ? seq : 4'd0;
    end

    // A redirect seen while decode only gets bubbles is parked until the next consume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            ibuf       <= 32'd0;
            redir_pend <= 1'b0;
            redir_pc   <= 32'd0;
            seq        <= 4'd1;
        end else if (consume) begin
            pc         <= next_pc;
            seq        <= (seq == 4'd15) ? 4'd1 : seq + 4'd1;
            redir_pend <= 1'b0;
        end else begin
            if (capture)
                ibuf <= imem.imem_rdata;
            if (cu_branch) begin
                redir_pend <= 1'b1;
                redir_pc   <= cu_bpc;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, hand-written corner sequences and a randomized
// run against a cycle-level reference model of the fetch rules.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        wpcir, cu_branch;
    logic [31:0] cu_bpc, if_inst, if_pc4;
    logic [3:0]  IF_ins_type, IF_ins_number;

    if_stage_if bus ();

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .wpcir         (wpcir),
        .cu_branch     (cu_branch),
        .cu_bpc        (cu_bpc),
        .imem          (bus.master),
        .if_inst       (if_inst),
        .if_pc4        (if_pc4),
        .IF_ins_type   (IF_ins_type),
        .IF_ins_number (IF_ins_number)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    int n_checks = 0;
    int n_fail   = 0;

    // Garbage on the data bus whenever the memory is not answering a request.
    assign bus.imem_rdata = (bus.imem_req && bus.imem_ready) ? mem[bus.imem_addr[9:2]] : 32'hDEAD_BEEF;

    typedef struct {
        logic        w;
        logic        br;
        logic [31:0] bpc;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc4;
        logic [3:0]  e_num;
    } vec_t;

    function automatic logic [3:0] ref_type(logic [31:0] w);
        logic [5:0] op, fn;
        op = w[31:26];
        fn = w[5:0];
        if (op == 6'h00) return (fn == 6'h08) ? 4'd7 : 4'd1;
        if (op == 6'h23) return 4'd3;
        if (op == 6'h2B) return 4'd4;
        if (op == 6'h04 || op == 6'h05) return 4'd5;
        if (op == 6'h02 || op == 6'h03) return 4'd6;
        return 4'd2;
    endfunction

    task automatic compare(string name, string field, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s.%s: got %h expected %h", name, field, act, exp);
        end
    endtask

    task automatic applyStimulus(logic w, logic br, logic [31:0] bpc, logic rdy);
        wpcir          = w;
        cu_branch      = br;
        cu_bpc         = bpc;
        bus.imem_ready = rdy;
    endtask

    task automatic checkOutput(string name, logic e_req, logic [31:0] e_addr, logic chk_addr,
                               logic e_valid, logic [31:0] e_pc4, logic [3:0] e_num);
        logic [31:0] p, e_inst;
        logic [3:0]  e_type;
        p      = e_pc4 - 32'd4;
        e_inst = e_valid ? mem[p[9:2]] : 32'd0;
        e_type = e_valid ? ref_type(e_inst) : 4'd0;
        compare(name, "imem_req", {31'd0, bus.imem_req}, {31'd0, e_req});
        if (chk_addr)
            compare(name, "imem_addr", bus.imem_addr, e_addr);
        compare(name, "if_inst", if_inst, e_inst);
        compare(name, "if_pc4", if_pc4, e_valid ? e_pc4 : 32'd0);
        compare(name, "IF_ins_type", {28'd0, IF_ins_type}, {28'd0, e_type});
        compare(name, "IF_ins_number", {28'd0, IF_ins_number}, {28'd0, e_num});
    endtask

    // Each step starts just after a rising edge and ends just after the next one.
    task automatic cycle(string name, logic w, logic br, logic [31:0] bpc, logic rdy,
                         logic e_req, logic [31:0] e_addr, logic e_valid,
                         logic [31:0] e_pc4, logic [3:0] e_num);
        applyStimulus(w, br, bpc, rdy);
        #2;
        checkOutput(name, e_req, e_addr, e_req, e_valid, e_pc4, e_num);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 4'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [5:0] ops [8];
    vec_t       vecs [9];
    logic [31:0] m_pc, m_pend_pc, r_bpc;
    logic        m_held, m_pend, present, r_w, r_br, r_rdy;
    int          m_seq;

    initial begin
        ops = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08};
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            mem[i][31:26] = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 3) == 0)
                mem[i][5:0] = 6'h08;
        end
        mem[2][31:26] = 6'h23;

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        doReset();

        // Streaming, a two-cycle stall on the lw at 8, then a redirect in the delay slot at C.
        vecs[0] = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'h00, 1'b1, 32'h04, 4'd1};
        vecs[1] = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'h04, 1'b1, 32'h08, 4'd2};
        vecs[2] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0C, 4'd3};
        vecs[3] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h08, 1'b1, 32'h0C, 4'd3};
        vecs[4] = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b0, 32'h08, 1'b1, 32'h0C, 4'd3};
        vecs[5] = '{1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h10, 4'd4};
        vecs[6] = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'h40, 1'b1, 32'h44, 4'd5};
        vecs[7] = '{1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 32'h44, 1'b0, 32'h00, 4'd0};
        vecs[8] = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'h44, 1'b1, 32'h48, 4'd6};
        for (int i = 0; i < 9; i++)
            cycle($sformatf("vec%0d", i), vecs[i].w, vecs[i].br, vecs[i].bpc, vecs[i].rdy,
                  vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_pc4, vecs[i].e_num);

        // Wait states at 0x10 with a redirect pulse during a bubble, then a wrap at 0xFFFFFFFC.
        doReset();
        for (int i = 0; i < 4; i++)
            cycle($sformatf("t4_pre%0d", i), 1'b1, 1'b0, 32'd0, 1'b1,
                  1'b1, 32'(4 * i), 1'b1, 32'(4 * i + 4), 4'(i + 1));
        cycle("t4_wait0", 1'b1, 1'b1, 32'h80, 1'b0, 1'b1, 32'h10, 1'b0, 32'd0, 4'd0);
        cycle("t4_wait1", 1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 32'h10, 1'b0, 32'd0, 4'd0);
        cycle("t4_wait2", 1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 32'h10, 1'b0, 32'd0, 4'd0);
        cycle("t4_slot", 1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'h10, 1'b1, 32'h14, 4'd5);
        cycle("t4_target", 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h80, 1'b1, 32'h84, 4'd6);
        cycle("wrap_top", 1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0, 4'd7);
        cycle("wrap_zero", 1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'h0, 1'b1, 32'h4, 4'd8);

        // Sequence tag wraps from 15 back to 1, never through 0.
        doReset();
        for (int i = 0; i < 16; i++)
            cycle($sformatf("seq%0d", i), 1'b1, 1'b0, 32'd0, 1'b1,
                  1'b1, 32'(4 * i), 1'b1, 32'(4 * i + 4), 4'((i % 15) + 1));

        // Reset during HOLD with a parked redirect.
        doReset();
        cycle("t6_a", 1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'h0, 1'b1, 32'h4, 4'd1);
        cycle("t6_b", 1'b0, 1'b1, 32'h80, 1'b1, 1'b1, 32'h4, 1'b1, 32'h8, 4'd2);
        cycle("t6_c", 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h4, 1'b1, 32'h8, 4'd2);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        #1;
        checkOutput("t6_hold", 1'b0, 32'h4, 1'b0, 1'b1, 32'h8, 4'd2);
        rst = 1'b1;
        #1;
        checkOutput("t6_rst", 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 4'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle("t6_post0", 1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'h0, 1'b1, 32'h4, 4'd1);
        cycle("t6_post1", 1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'h4, 1'b1, 32'h8, 4'd2);

        // Randomized run; the model tracks fetch address, held instruction and parked redirect.
        doReset();
        m_pc      = 32'd0;
        m_pend_pc = 32'd0;
        m_held    = 1'b0;
        m_pend    = 1'b0;
        m_seq     = 1;
        for (int i = 0; i < 400; i++) begin
            r_w   = ($urandom_range(0, 3) != 0);
            r_rdy = ($urandom_range(0, 2) != 0);
            r_br  = ($urandom_range(0, 5) == 0);
            r_bpc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 255)) << 2;
            present = m_held || r_rdy;
            cycle($sformatf("rand%0d", i), r_w, r_br, r_bpc, r_rdy,
                  !m_held, m_pc, present, present ? m_pc + 32'd4 : 32'd0,
                  present ? 4'(m_seq) : 4'd0);
            if (present && r_w) begin
                if (r_br)
                    m_pc = r_bpc;
                else if (m_pend)
                    m_pc = m_pend_pc;
                else
                    m_pc = m_pc + 32'd4;
                m_pend = 1'b0;
                m_held = 1'b0;
                m_seq  = (m_seq % 15) + 1;
            end else begin
                if (present)
                    m_held = 1'b1;
                if (r_br) begin
                    m_pend    = 1'b1;
                    m_pend_pc = r_bpc;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
